// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt sequencer slice.
package intseq_pkg;

    localparam int unsigned VECTOR_WIDTH = 16;
    localparam int unsigned MAX_INPUTS   = 16;
    localparam int unsigned IDX_WIDTH    = 4;

    // Legacy state encodings; the enum below is bound to these values.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;
    localparam logic [1:0] ST_SERVICE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        PENDING = ST_PENDING,
        CLEAR   = ST_CLEAR,
        SERVICE = ST_SERVICE
    } state_t;

    // Vector address of a source; wraps modulo 2^VECTOR_WIDTH.
    function automatic logic [VECTOR_WIDTH-1:0] calc_vector(
        input logic [VECTOR_WIDTH-1:0] base,
        input logic [IDX_WIDTH-1:0]    idx,
        input int unsigned             shift
    );
        logic [VECTOR_WIDTH-1:0] offset;
        offset = VECTOR_WIDTH'(idx) << shift;
        return base + offset;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Controller-side and CPU-side signals of the interrupt sequencer.
interface interrupt_sequencer_if #(
    parameter int unsigned NUM_INPUTS = 16
) ();
    import intseq_pkg::*;

    logic                    int_in;
    logic [NUM_INPUTS-1:0]   active_in;
    logic [NUM_INPUTS-1:0]   active_wdata;
    logic                    active_write;
    logic                    cpu_int_enable;
    logic                    irq_out;
    logic                    cpu_ack;
    logic                    cpu_eoi;
    logic [VECTOR_WIDTH-1:0] vector_out;
    logic                    in_service;
    logic [IDX_WIDTH-1:0]    service_idx;

    // Sequencer side.
    modport slave (
        input  int_in, active_in, cpu_int_enable, cpu_ack, cpu_eoi,
        output active_wdata, active_write, irq_out, vector_out, in_service, service_idx
    );

    // Controller/CPU side.
    modport master (
        output int_in, active_in, cpu_int_enable, cpu_ack, cpu_eoi,
        input  active_wdata, active_write, irq_out, vector_out, in_service, service_idx
    );

endinterface

// File: rtl/interrupt_sequencer_priority_encoder.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module priority_encoder
    import intseq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 16
) (
    input  logic [NUM_INPUTS-1:0] req,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  valid
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = NUM_INPUTS; i > 0; i--) begin
            if (req[i-1]) begin
                idx   = IDX_WIDTH'(i - 1);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Picks the highest-priority active source, requests the CPU, clears the
// serviced bit in the controller on acknowledge and waits for end-of-interrupt.
module interrupt_sequencer
    import intseq_pkg::*;
#(
    parameter int unsigned             NUM_INPUTS   = 16,
    parameter logic [VECTOR_WIDTH-1:0] VECTOR_BASE  = 16'h0000,
    parameter int unsigned             VECTOR_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_sequencer_if.slave  bus
);

    state_t                  state, state_nxt;
    logic [IDX_WIDTH-1:0]    idx_q, idx_nxt;
    logic [VECTOR_WIDTH-1:0] vec_q, vec_nxt;
    logic [IDX_WIDTH-1:0]    enc_idx;
    logic                    enc_valid;
    logic [NUM_INPUTS-1:0]   clr_mask;

    priority_encoder #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_prio (
        .req   (bus.active_in),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Next-state, index and vector selection.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        vec_nxt   = vec_q;
        case (state)
            IDLE: begin
                if (bus.int_in && bus.cpu_int_enable && enc_valid) begin
                    state_nxt = PENDING;
                    idx_nxt   = enc_idx;
                    vec_nxt   = calc_vector(VECTOR_BASE, enc_idx, VECTOR_SHIFT);
                end
            end
            PENDING: begin
                // Ack freezes the selection; otherwise track the current winner.
                if (bus.cpu_ack) begin
                    state_nxt = CLEAR;
                end else if (!enc_valid || !bus.cpu_int_enable) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt = enc_idx;
                    vec_nxt = calc_vector(VECTOR_BASE, enc_idx, VECTOR_SHIFT);
                end
            end
            CLEAR: begin
                state_nxt = SERVICE;
            end
            SERVICE: begin
                if (bus.cpu_eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, index and vector registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx_q <= '0;
            vec_q <= '0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            vec_q <= vec_nxt;
        end
    end

    // Outputs decode from state; the clear value uses live active_in so
    // bits arriving during CLEAR are preserved.
    always_comb begin
        clr_mask          = NUM_INPUTS'(1) << idx_q;
        bus.irq_out       = (state == PENDING);
        bus.active_write  = (state == CLEAR);
        bus.active_wdata  = (state == CLEAR) ? (bus.active_in & ~clr_mask) : '0;
        bus.in_service    = (state == SERVICE);
        bus.service_idx   = idx_q;
        bus.vector_out    = vec_q;
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: vector table with a scoreboard
// queue, plus hand-written asynchronous-reset and vector-wrap sequences.
module tb_interrupt_sequencer;

    logic clk;
    logic reset;

    interrupt_sequencer_if #(.NUM_INPUTS(16)) if0 ();
    interrupt_sequencer_if #(.NUM_INPUTS(16)) if1 ();

    interrupt_sequencer #(
        .NUM_INPUTS   (16),
        .VECTOR_BASE  (16'h0000),
        .VECTOR_SHIFT (2)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    interrupt_sequencer #(
        .NUM_INPUTS   (16),
        .VECTOR_BASE  (16'hFFF0),
        .VECTOR_SHIFT (2)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    typedef struct {
        logic        irq;
        logic [3:0]  idx;
        logic [15:0] vec;
        logic        aw;
        logic [15:0] awd;
        logic        insvc;
    } exp_t;

    typedef struct {
        logic [15:0] act;
        logic        int_in;
        logic        en;
        logic        ack;
        logic        eoi;
        exp_t        exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk_exp(logic irq, logic [3:0] idx, logic [15:0] vec,
                                    logic aw, logic [15:0] awd, logic insvc);
        exp_t e;
        e.irq = irq; e.idx = idx; e.vec = vec; e.aw = aw; e.awd = awd; e.insvc = insvc;
        return e;
    endfunction

    task automatic add(logic [15:0] act, logic int_in, logic en, logic ack, logic eoi,
                       logic irq, logic [3:0] idx, logic [15:0] vec,
                       logic aw, logic [15:0] awd, logic insvc);
        vec_t v;
        v.act = act; v.int_in = int_in; v.en = en; v.ack = ack; v.eoi = eoi;
        v.exp = mk_exp(irq, idx, vec, aw, awd, insvc);
        tbl.push_back(v);
    endtask

    task automatic check_out(string name, exp_t e);
        n_tests++;
        if (if0.irq_out !== e.irq || if0.service_idx !== e.idx || if0.vector_out !== e.vec ||
            if0.active_write !== e.aw || if0.active_wdata !== e.awd || if0.in_service !== e.insvc) begin
            n_fail++;
            $display("FAIL %s: got irq=%b idx=%0d vec=%h aw=%b awd=%h insvc=%b, want irq=%b idx=%0d vec=%h aw=%b awd=%h insvc=%b",
                     name, if0.irq_out, if0.service_idx, if0.vector_out, if0.active_write,
                     if0.active_wdata, if0.in_service, e.irq, e.idx, e.vec, e.aw, e.awd, e.insvc);
        end
    endtask

    task automatic check_val(string name, logic [15:0] got, logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive0(logic [15:0] act, logic int_in, logic en, logic ack, logic eoi);
        if0.active_in      = act;
        if0.int_in         = int_in;
        if0.cpu_int_enable = en;
        if0.cpu_ack        = ack;
        if0.cpu_eoi        = eoi;
    endtask

    initial begin
        exp_t e;

        // act, int, en, ack, eoi  ->  irq, idx, vec, aw, awd, insvc (after the edge)
        for (int i = 0; i < 10; i++) add(16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0);
        // Basic request, ack, clear, service, eoi
        add(16'h0024, 1, 1, 0, 0, 1, 2, 16'h0008, 0, 16'h0000, 0);
        add(16'h0024, 1, 1, 1, 0, 0, 2, 16'h0008, 1, 16'h0020, 0);
        add(16'h0024, 1, 1, 0, 0, 0, 2, 16'h0008, 0, 16'h0000, 1);
        add(16'h0020, 1, 1, 0, 0, 0, 2, 16'h0008, 0, 16'h0000, 1);
        add(16'h0020, 1, 1, 0, 1, 0, 2, 16'h0008, 0, 16'h0000, 0);
        add(16'h0020, 1, 1, 0, 0, 1, 5, 16'h0014, 0, 16'h0000, 0);
        // Pre-ack preemption, then ack while bit 0 rises keeps idx 1
        add(16'h0022, 1, 1, 0, 0, 1, 1, 16'h0004, 0, 16'h0000, 0);
        add(16'h0023, 1, 1, 1, 0, 0, 1, 16'h0004, 1, 16'h0021, 0);
        add(16'h0023, 1, 1, 0, 0, 0, 1, 16'h0004, 0, 16'h0000, 1);
        add(16'h0021, 1, 1, 0, 0, 0, 1, 16'h0004, 0, 16'h0000, 1);
        add(16'h0021, 1, 1, 1, 0, 0, 1, 16'h0004, 0, 16'h0000, 1);
        add(16'h0021, 1, 1, 0, 1, 0, 1, 16'h0004, 0, 16'h0000, 0);
        add(16'h0021, 1, 1, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
        add(16'h0021, 1, 1, 1, 0, 0, 0, 16'h0000, 1, 16'h0020, 0);
        add(16'h0021, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1);
        // New bit in SERVICE holds off until eoi; re-request two cycles after eoi
        add(16'h0028, 1, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1);
        add(16'h0028, 1, 1, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
        add(16'h0028, 1, 1, 0, 0, 1, 3, 16'h000C, 0, 16'h0000, 0);
        add(16'h0028, 1, 1, 0, 1, 1, 3, 16'h000C, 0, 16'h0000, 0);
        // Software clears the bitmap while pending: no write ever issued
        add(16'h0000, 0, 1, 0, 0, 0, 3, 16'h000C, 0, 16'h0000, 0);
        add(16'h0000, 0, 1, 1, 0, 0, 3, 16'h000C, 0, 16'h0000, 0);
        add(16'h0000, 1, 1, 0, 0, 0, 3, 16'h000C, 0, 16'h0000, 0);
        add(16'h0010, 0, 1, 0, 0, 0, 3, 16'h000C, 0, 16'h0000, 0);
        // Global enable gating and enable drop while pending
        add(16'h0010, 1, 0, 0, 0, 0, 3, 16'h000C, 0, 16'h0000, 0);
        add(16'h0010, 1, 1, 0, 0, 1, 4, 16'h0010, 0, 16'h0000, 0);
        add(16'h0010, 1, 0, 0, 0, 0, 4, 16'h0010, 0, 16'h0000, 0);
        add(16'h0000, 0, 1, 0, 0, 0, 4, 16'h0010, 0, 16'h0000, 0);

        reset = 1'b0;
        drive0(16'h0000, 0, 0, 0, 0);
        if1.active_in = '0; if1.int_in = 0; if1.cpu_int_enable = 0;
        if1.cpu_ack = 0; if1.cpu_eoi = 0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", mk_exp(0, 0, 16'h0000, 0, 16'h0000, 0));
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive0(tbl[i].act, tbl[i].int_in, tbl[i].en, tbl[i].ack, tbl[i].eoi);
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_underflow: got 0 entries, want 1");
            end else begin
                e = sb.pop_front();
                check_out($sformatf("row%0d", i), e);
            end
        end

        // Asynchronous reset in the CLEAR cycle
        @(negedge clk);
        drive0(16'h0024, 1, 1, 0, 0);
        @(posedge clk); #1;
        check_out("async_pending", mk_exp(1, 2, 16'h0008, 0, 16'h0000, 0));
        @(negedge clk);
        drive0(16'h0024, 1, 1, 1, 0);
        @(posedge clk); #1;
        check_out("async_clear", mk_exp(0, 2, 16'h0008, 1, 16'h0020, 0));
        #1;
        reset = 1'b0;
        #1;
        check_out("async_reset_mid_cycle", mk_exp(0, 0, 16'h0000, 0, 16'h0000, 0));
        @(negedge clk);
        drive0(16'h0000, 0, 1, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_out("after_async_reset", mk_exp(0, 0, 16'h0000, 0, 16'h0000, 0));

        // Vector wrap with VECTOR_BASE=16'hFFF0
        @(negedge clk);
        if1.active_in = 16'h0080; if1.int_in = 1; if1.cpu_int_enable = 1;
        @(posedge clk); #1;
        check_val("wrap_vec_idx7", if1.vector_out, 16'h000C);
        check_val("wrap_idx7", {12'h000, if1.service_idx}, 16'h0007);
        @(negedge clk);
        if1.active_in = 16'h0081;
        @(posedge clk); #1;
        check_val("wrap_vec_idx0", if1.vector_out, 16'hFFF0);
        check_val("wrap_irq", {15'h0000, if1.irq_out}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
